ad9833_sweep_seq: RTL and testbench

- Upstream sequencer for the AD9833 serial interface block (ad9833if).
- Generates the control/frequency words and the go handshake that the top level currently produces by hand.
- Issues one reset/init write, then steps the 28-bit frequency word from a start value to a stop value, dwelling a programmable number of clocks at each tone.
- Supports single-pass or looping sweeps; reports busy/done status to the top level.

---
 rtl/ad9833_sweep_seq.sv | 163 ++++++++++++++++
 tb/tb_ad9833_sweep_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ad9833_sweep_seq.sv
// Frequency-sweep sequencer feeding ad9833if: one init write, then stepped tone
// writes with a programmable dwell, single-pass or looping.
module ad9833_sweep_seq #(
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter logic [15:0] CTRL_INIT    = 16'h2100,
  parameter logic [15:0] CTRL_RUN     = 16'h2000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_loop,
  input  logic [27:0] i_start_freq,
  input  logic [27:0] i_stop_freq,
  input  logic [27:0] i_step,
  input  logic        i_good_to_reset_go,
  input  logic        i_send_complete,
  output logic        o_go,
  output logic [15:0] o_control,
  output logic [27:0] o_freq,
  output logic        o_busy,
  output logic        o_sweep_done
);

  localparam int unsigned CW = $clog2(DWELL_CYCLES + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT_SEND, S_INIT_WAIT, S_TONE_SEND,
    S_TONE_WAIT, S_DWELL, S_STEP, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          en_prev_q, en_prev_d;
  logic          go_q, go_d;
  logic [15:0]   control_q, control_d;
  logic [27:0]   freq_q, freq_d;
  logic [27:0]   start_q, start_d;
  logic [27:0]   stop_q, stop_d;
  logic [27:0]   step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  logic [28:0]   next_freq;
  logic          frame_end;
  logic          in_init;

  always_comb begin
    state_d   = state_q;
    en_prev_d = i_enable;
    go_d      = go_q;
    control_d = control_q;
    freq_d    = freq_q;
    start_d   = start_q;
    stop_d    = stop_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;

    next_freq = {1'b0, freq_q} + {1'b0, step_q};
    in_init   = (state_q == S_INIT_SEND) || (state_q == S_INIT_WAIT);
    // An ack plus completion in the same SEND cycle ends the frame at once.
    frame_end = (((state_q == S_INIT_SEND) || (state_q == S_TONE_SEND)) &&
                 i_good_to_reset_go && i_send_complete) ||
                (((state_q == S_INIT_WAIT) || (state_q == S_TONE_WAIT)) &&
                 i_send_complete);

    case (state_q)
      S_IDLE: begin
        if (i_enable && !en_prev_q) begin
          start_d   = i_start_freq;
          stop_d    = i_stop_freq;
          step_d    = i_step;
          freq_d    = i_start_freq;
          control_d = CTRL_INIT;
          go_d      = 1'b1;
          state_d   = S_INIT_SEND;
        end
      end
      S_INIT_SEND, S_TONE_SEND: begin
        if (i_good_to_reset_go) begin
          go_d    = 1'b0;
          state_d = (state_q == S_INIT_SEND) ? S_INIT_WAIT : S_TONE_WAIT;
        end
      end
      S_DWELL: begin
        if (!i_enable) begin
          state_d = S_IDLE;
        end else if (cnt_q == DWELL_LAST) begin
          state_d = S_STEP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STEP: begin
        if (!i_enable) begin
          state_d = S_IDLE;
        end else if ((step_q != '0) && !next_freq[28] && (next_freq[27:0] <= stop_q)) begin
          freq_d  = next_freq[27:0];
          go_d    = 1'b1;
          state_d = S_TONE_SEND;
        end else if ((step_q != '0) && i_loop) begin
          freq_d  = start_q;
          go_d    = 1'b1;
          state_d = S_TONE_SEND;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!i_enable) state_d = S_IDLE;
      end
      default: ;
    endcase

    if (frame_end) begin
      go_d = 1'b0;
      if (!i_enable) begin
        state_d = S_IDLE;
      end else if (in_init) begin
        control_d = CTRL_RUN;
        go_d      = 1'b1;
        state_d   = S_TONE_SEND;
      end else begin
        cnt_d   = '0;
        state_d = S_DWELL;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      en_prev_q <= 1'b1;
      go_q      <= 1'b0;
      control_q <= '0;
      freq_q    <= '0;
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_prev_q <= en_prev_d;
      go_q      <= go_d;
      control_q <= control_d;
      freq_q    <= freq_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

  assign o_go         = go_q;
  assign o_control    = control_q;
  assign o_freq       = freq_q;
  assign o_busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_sweep_done = done_q;

endmodule

// File: tb/tb_ad9833_sweep_seq.sv
// Directed bench for ad9833_sweep_seq; the bench plays the ad9833if side of the handshake.
module tb_ad9833_sweep_seq;

  logic        clk = 1'b0;
  logic        i_rst, i_enable, i_loop;
  logic [27:0] i_start_freq, i_stop_freq, i_step;
  logic        i_good_to_reset_go, i_send_complete;
  logic        o_go, o_busy, o_sweep_done;
  logic [15:0] o_control;
  logic [27:0] o_freq;

  int total = 0;
  int bad   = 0;
  int gap;

  always #5 clk = ~clk;

  ad9833_sweep_seq #(.DWELL_CYCLES(8)) dut (
    .i_clk              (clk),
    .i_rst              (i_rst),
    .i_enable           (i_enable),
    .i_loop             (i_loop),
    .i_start_freq       (i_start_freq),
    .i_stop_freq        (i_stop_freq),
    .i_step             (i_step),
    .i_good_to_reset_go (i_good_to_reset_go),
    .i_send_complete    (i_send_complete),
    .o_go               (o_go),
    .o_control          (o_control),
    .o_freq             (o_freq),
    .o_busy             (o_busy),
    .o_sweep_done       (o_sweep_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for go, checks the word, acks after ack_dly, completes after cmp_dly.
  task automatic serve(input string tag, input logic [15:0] ec, input logic [27:0] ef,
                       input int ack_dly, input int cmp_dly, input bit both,
                       input bit drop_en, output int g);
    int n;
    bit ok;
    n = 0;
    while (o_go !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    g = n;
    chk({tag, ".go"}, 32'(o_go), 32'd1);
    if (o_go !== 1'b1) return;
    chk({tag, ".ctrl"}, 32'(o_control), 32'(ec));
    chk({tag, ".freq"}, 32'(o_freq), 32'(ef));
    ok = 1'b1;
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      if (o_go !== 1'b1 || o_control !== ec || o_freq !== ef) ok = 1'b0;
    end
    i_good_to_reset_go = 1'b1;
    if (both) i_send_complete = 1'b1;
    @(negedge clk);
    i_good_to_reset_go = 1'b0;
    i_send_complete    = 1'b0;
    if (drop_en) i_enable = 1'b0;
    if (!both) begin
      if (o_go !== 1'b0) ok = 1'b0;
      for (int i = 0; i < cmp_dly; i++) begin
        @(negedge clk);
        if (o_go !== 1'b0 || o_control !== ec || o_freq !== ef) ok = 1'b0;
      end
      i_send_complete = 1'b1;
      @(negedge clk);
      i_send_complete = 1'b0;
    end
    chk({tag, ".hold"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    bit saw_go;
    n = 0;
    saw_go = 1'b0;
    while (o_sweep_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (o_go === 1'b1) saw_go = 1'b1;
    end
    chk({tag, ".done"}, 32'(o_sweep_done), 32'd1);
    chk({tag, ".busy_fall"}, 32'(o_busy), 32'd0);
    chk({tag, ".done_gap"}, 32'(n), 32'd9);
    chk({tag, ".no_go"}, 32'(saw_go), 32'd0);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(o_sweep_done), 32'd0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    bit act;
    act = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (o_go !== 1'b0 || o_busy !== 1'b0) act = 1'b1;
    end
    chk({tag, ".quiet"}, 32'(act), 32'd0);
  endtask

  task automatic arm(input logic [27:0] s, input logic [27:0] e, input logic [27:0] st, input logic lp);
    i_enable = 1'b0;
    repeat (2) @(negedge clk);
    i_start_freq = s;
    i_stop_freq  = e;
    i_step       = st;
    i_loop       = lp;
    i_enable     = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".go"},   32'(o_go), 32'd0);
    chk({tag, ".ctrl"}, 32'(o_control), 32'd0);
    chk({tag, ".freq"}, 32'(o_freq), 32'd0);
    chk({tag, ".busy"}, 32'(o_busy), 32'd0);
    chk({tag, ".done"}, 32'(o_sweep_done), 32'd0);
  endtask

  initial begin
    i_rst = 1'b1; i_enable = 1'b0; i_loop = 1'b0;
    i_start_freq = '0; i_stop_freq = '0; i_step = '0;
    i_good_to_reset_go = 1'b0; i_send_complete = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    i_rst = 1'b0;
    repeat (2) @(negedge clk);

    // single pass 0x10..0x30 step 0x10
    arm(28'h10, 28'h30, 28'h10, 1'b0);
    serve("sp_init", 16'h2100, 28'h10, 0, 2, 0, 0, gap);
    chk("sp_init.gap", 32'(gap), 32'd1);
    chk("sp.busy", 32'(o_busy), 32'd1);
    serve("sp_t10", 16'h2000, 28'h10, 0, 2, 0, 0, gap);
    chk("sp_t10.gap", 32'(gap), 32'd0);
    serve("sp_t20", 16'h2000, 28'h20, 1, 3, 0, 0, gap);
    chk("sp_t20.gap", 32'(gap), 32'd9);
    serve("sp_t30", 16'h2000, 28'h30, 0, 2, 0, 0, gap);
    chk("sp_t30.gap", 32'(gap), 32'd9);
    wait_done("sp");
    chk("sp.last_tone", 32'(o_freq), 32'h30);

    // looping sweep, enable dropped in TONE_WAIT
    arm(28'h10, 28'h30, 28'h10, 1'b1);
    serve("lp_init", 16'h2100, 28'h10, 0, 2, 0, 0, gap);
    serve("lp_t10", 16'h2000, 28'h10, 0, 2, 0, 0, gap);
    serve("lp_t20", 16'h2000, 28'h20, 0, 2, 0, 0, gap);
    serve("lp_t30", 16'h2000, 28'h30, 0, 2, 0, 0, gap);
    serve("lp_wrap", 16'h2000, 28'h10, 0, 2, 0, 0, gap);
    chk("lp_wrap.gap", 32'(gap), 32'd9);
    serve("lp_t20b", 16'h2000, 28'h20, 0, 4, 0, 1, gap);
    chk("lp_stop.busy", 32'(o_busy), 32'd0);
    quiet("lp_stop", 20);

    // slow handshake, enable dropped in DWELL
    arm(28'h100, 28'h200, 28'h80, 1'b0);
    serve("slow_init", 16'h2100, 28'h100, 5, 200, 0, 0, gap);
    serve("slow_t", 16'h2000, 28'h100, 5, 200, 0, 0, gap);
    repeat (3) @(negedge clk);
    i_enable = 1'b0;
    @(negedge clk);
    chk("dwell_stop.busy", 32'(o_busy), 32'd0);
    chk("dwell_stop.freq", 32'(o_freq), 32'h100);
    quiet("dwell_stop", 15);

    // 29-bit overflow, ack and completion together on the tone
    arm(28'hFFFFFF0, 28'hFFFFFFF, 28'h20, 1'b0);
    serve("ovf_init", 16'h2100, 28'hFFFFFF0, 0, 2, 0, 0, gap);
    serve("ovf_t", 16'h2000, 28'hFFFFFF0, 0, 0, 1, 0, gap);
    wait_done("ovf");

    // step of zero ignores loop
    arm(28'h50, 28'h60, 28'h0, 1'b1);
    serve("z_init", 16'h2100, 28'h50, 0, 1, 0, 0, gap);
    serve("z_t", 16'h2000, 28'h50, 0, 1, 0, 0, gap);
    wait_done("z");

    // start above stop, single pass then looping
    arm(28'h100, 28'h50, 28'h1, 1'b0);
    serve("inv_init", 16'h2100, 28'h100, 0, 1, 0, 0, gap);
    serve("inv_t", 16'h2000, 28'h100, 0, 1, 0, 0, gap);
    wait_done("inv");
    arm(28'h100, 28'h50, 28'h1, 1'b1);
    serve("invl_init", 16'h2100, 28'h100, 0, 1, 0, 0, gap);
    serve("invl_t", 16'h2000, 28'h100, 0, 1, 0, 0, gap);
    serve("invl_rep", 16'h2000, 28'h100, 0, 1, 0, 1, gap);
    chk("invl_rep.gap", 32'(gap), 32'd9);
    chk("invl_stop.busy", 32'(o_busy), 32'd0);

    // async reset mid-DWELL, enable held through release
    arm(28'h10, 28'h30, 28'h10, 1'b0);
    serve("rd_init", 16'h2100, 28'h10, 0, 1, 0, 0, gap);
    serve("rd_t", 16'h2000, 28'h10, 0, 1, 0, 0, gap);
    repeat (3) @(negedge clk);
    #2 i_rst = 1'b1;
    #1 chk_zero("rst_dwell");
    @(negedge clk);
    i_rst = 1'b0;
    quiet("rst_dwell_hold", 30);

    // async reset mid-SEND
    arm(28'h10, 28'h30, 28'h10, 1'b0);
    @(negedge clk);
    chk("rs.go", 32'(o_go), 32'd1);
    #2 i_rst = 1'b1;
    #1 chk_zero("rst_send");
    @(negedge clk);
    i_rst = 1'b0;
    quiet("rst_send_hold", 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
